// File: rtl/alu_iter.sv
//------------------------------------------------------------------------------
// alu_iter: single-cycle ALU plus radix-2 iterative multiply/divide (start/busy/done).
// Define ALU_ITER_DIV_EN to build the restoring divider and the DIV/DIVU opcodes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_iter #(
  parameter int WIDTH            = 32,
  parameter int SHW              = $clog2(WIDTH),
  parameter int ALU_OPCODE_WIDTH = 5
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [ALU_OPCODE_WIDTH-1:0] opcode,
  input  logic [WIDTH-1:0]            src1,
  input  logic [WIDTH-1:0]            src2,
  output logic [WIDTH-1:0]            result,
  output logic [WIDTH-1:0]            result_hi,
  output logic                        busy,
  output logic                        done
);

  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_ADD   = 5'd0,  ALU_ADDU  = 5'd1,
                                          ALU_SUB   = 5'd2,  ALU_SUBU  = 5'd3,
                                          ALU_AND   = 5'd4,  ALU_OR    = 5'd5,
                                          ALU_NOR   = 5'd6,  ALU_XOR   = 5'd7,
                                          ALU_SLL   = 5'd8,  ALU_SRL   = 5'd9,
                                          ALU_SRA   = 5'd10, ALU_ROR   = 5'd11,
                                          ALU_SEQ   = 5'd12, ALU_SLT   = 5'd13,
                                          ALU_SLTU  = 5'd14, ALU_MULT  = 5'd15,
                                          ALU_MULTU = 5'd16;
`ifdef ALU_ITER_DIV_EN
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_DIV   = 5'd17, ALU_DIVU  = 5'd18;
`endif

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2;

  logic [1:0]         r_state, w_state_nxt;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_step, w_mul_next, w_prod;
  logic [WIDTH-1:0]   r_b, r_result, r_result_hi, w_alu, w_mag1, w_mag2;
  logic [WIDTH:0]     w_madd;
  logic [SHW-1:0]     w_sh;
  logic [SHW:0]       w_rol_amt;
  logic               r_neg_lo, r_done, w_single, w_is_mul, w_multi;
  logic               w_signed_op, w_neg1, w_neg2, w_busy;

  // Single-cycle operations
  assign w_sh      = src1[SHW-1:0];
  assign w_rol_amt = (SHW+1)'(WIDTH) - {1'b0, w_sh};

  always_comb begin
    w_alu    = '0;
    w_single = 1'b1;
    case (opcode)
      ALU_ADD, ALU_ADDU: w_alu = src1 + src2;
      ALU_SUB, ALU_SUBU: w_alu = src1 - src2;
      ALU_AND:  w_alu = src1 & src2;
      ALU_OR:   w_alu = src1 | src2;
      ALU_NOR:  w_alu = ~(src1 | src2);
      ALU_XOR:  w_alu = src1 ^ src2;
      ALU_SLL:  w_alu = src2 << w_sh;
      ALU_SRL:  w_alu = src2 >> w_sh;
      ALU_SRA:  w_alu = $signed(src2) >>> w_sh;
      ALU_ROR:  w_alu = (src2 >> w_sh) | (src2 << w_rol_amt);
      ALU_SEQ:  w_alu = {{(WIDTH-1){1'b0}}, src1 == src2};
      ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
      ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, src1 < src2};
      default:  w_single = 1'b0;
    endcase
  end

  assign w_is_mul = (opcode == ALU_MULT) || (opcode == ALU_MULTU);

  // Multiply: shift-add, multiplier consumed from the low half of the accumulator
  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};
  assign w_prod     = r_neg_lo ? -r_acc : r_acc;

`ifdef ALU_ITER_DIV_EN
  logic               r_is_div, r_neg_hi, r_dz, w_is_div;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_is_div    = (opcode == ALU_DIV) || (opcode == ALU_DIVU);
  assign w_multi     = w_is_mul || w_is_div;
  assign w_signed_op = (opcode == ALU_MULT) || (opcode == ALU_DIV);
  // Restoring divide: remainder in the high half, quotient bits shift into the low half
  assign w_trial     = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
  assign w_div_next  = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_step      = r_is_div ? w_div_next : w_mul_next;
`else
  assign w_multi     = w_is_mul;
  assign w_signed_op = (opcode == ALU_MULT);
  assign w_step      = w_mul_next;
`endif

  assign w_neg1 = w_signed_op & src1[WIDTH-1];
  assign w_neg2 = w_signed_op & src2[WIDTH-1];
  assign w_mag1 = w_neg1 ? -src1 : src1;
  assign w_mag2 = w_neg2 ? -src2 : src2;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && w_multi) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_b         <= '0;
      r_neg_lo    <= 1'b0;
`ifdef ALU_ITER_DIV_EN
      r_is_div    <= 1'b0;
      r_neg_hi    <= 1'b0;
      r_dz        <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && w_single) begin
            r_result    <= w_alu;
            r_result_hi <= '0;
            r_done      <= 1'b1;
          end else if (start && w_multi) begin
            r_acc    <= {{WIDTH{1'b0}}, w_mag1};
            r_b      <= w_mag2;
            r_neg_lo <= w_neg1 ^ w_neg2;
            r_cnt    <= SHW'(WIDTH-1);
`ifdef ALU_ITER_DIV_EN
            r_is_div <= w_is_div;
            r_neg_hi <= w_neg1;
            r_dz     <= (src2 == '0);
`endif
          end
        end
        S_RUN: begin
          r_acc <= w_step;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_done <= 1'b1;
`ifdef ALU_ITER_DIV_EN
          // Divide by zero keeps an all-ones quotient regardless of operand signs
          if (r_is_div) begin
            r_result    <= r_dz ? '1 : (r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
            r_result_hi <= r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
          end else
`endif
          begin
            r_result    <= w_prod[WIDTH-1:0];
            r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign busy      = w_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: doc/alu_iter.md
# alu_iter

Parametrised successor to the CPU's single-cycle ALU, placed in the execute stage. It keeps the one-cycle logic, shift, compare and add/subtract operations, generalised to `WIDTH` bits. It adds iterative multiply and divide: a radix-2 shift-add/shift-subtract datapath, one bit per cycle, signalled through a `start`/`busy`/`done` handshake. The issue logic treats `busy` as a structural stall and `done` as the writeback strobe.

## Interface
- `WIDTH`, default 32: operand and result width; must be a power of two, ≥ 8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; never overridden.
- `CLK`  in  1: clock; all logic on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `start`  in  1: operation request. Sampled only when `busy`=0.
- `opcode`  in  `ALU_OPCODE_WIDTH`: `ALU_*` code from opcode.h. New codes `ALU_MULT`, `ALU_MULTU`, `ALU_DIV` and `ALU_DIVU` are added there.
- `src1`  in  `WIDTH`: operand 1; shift amount is `src1[SHW-1:0]`.
- `src2`  in  `WIDTH`: operand 2; the shifted value for shift ops.
- `result`  out  `WIDTH`: primary result: single-cycle result, product low half, or quotient.
- `result_hi`  out  `WIDTH`: product high half or remainder; 0 for single-cycle ops.
- `busy`  out  1: a multi-cycle operation is in flight.
- `done`  out  1: one-cycle pulse; `result`/`result_hi` valid in the same cycle and held until the next `done`.

## Operation
- State machine: `IDLE`, `RUN`, `FIX`.
- `IDLE`, `start`=1, single-cycle op:
  - Ops: `ADD`, `ADDU`, `SUB`, `SUBU`, `AND`, `OR`, `NOR`, `XOR`, `SLL`, `SRL`, `SRA`, `ROR`, `SEQ`, `SLT`, `SLTU`.
  - Next edge: `result` written, `result_hi`<=0, `done`<=1; state stays `IDLE`.
  - Arithmetic wraps modulo 2^WIDTH; no overflow trap.
  - `ROR` by 0 returns `src2`.
  - `SEQ`/`SLT`/`SLTU` return 1 or 0, zero-extended.
- `IDLE`, `start`=1, MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes (absolute values for the signed ops) and the result-sign flags.
  - `cnt`<=WIDTH-1; `busy`<=1; go to `RUN`.
- `RUN`: one iteration per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - `cnt` decrements; when `cnt`==0, go to `FIX`.
- `FIX`:
  - Apply sign correction. The quotient takes sign(src1)^sign(src2); the remainder takes sign(src1).
  - Write `result`/`result_hi`; `done`<=1; `busy`<=0; go to `IDLE`.
- Divide by zero, both DIV and DIVU: `result` = all ones, `result_hi` = `src1`. Takes the same latency as a normal divide.
- Signed DIV of most-negative by −1: `result` = most-negative, `result_hi` = 0.
- Unknown opcode with `start`: no `done` and no `busy`; outputs unchanged.
- `start` while `busy`=1: ignored; no queuing.
- `done` is 0 in every cycle not listed above.

## Timing
- Reset values: `result`=0, `result_hi`=0, `busy`=0, `done`=0, state `IDLE`, `cnt`=0.
- Single-cycle ops: `done` rises one cycle after the cycle in which `start` is sampled.
- MUL/DIV: `busy` is high for WIDTH+1 cycles (`RUN` ×WIDTH, then `FIX`). `done` rises the cycle after `FIX`, with `busy` simultaneously 0. Total latency is WIDTH+2 cycles from the `start` sample; 34 for WIDTH=32.
- Back-to-back: a new `start` may be presented in the same cycle `done` is high and is accepted.
- `RST` during `RUN`/`FIX`: the operation is aborted with no `done`, and all outputs take their reset values at that edge.

## Configuration
- `ALU_ITER_DIV_EN` defined: the divider datapath and the DIV/DIVU opcodes are present as specified.
- Not defined: no divider logic is generated. DIV/DIVU are treated as unknown opcodes (no `done`, no `busy`). MULT/MULTU are unaffected.

## Test plan
- Reset, then `ADD` with 0xFFFFFFFF + 1: `done` 1 cycle later, `result`=0, `result_hi`=0.
- `MULT` with 0xFFFFFFFE (−2) × 3: `busy` for 33 cycles, `done` at cycle 34, `result`=0xFFFFFFFA, `result_hi`=0xFFFFFFFF. `MULTU` with the same operands: `result`=0xFFFFFFFA, `result_hi`=0x2.
- `DIV` with −7 ÷ 2: `result`=0xFFFFFFFD, `result_hi`=0xFFFFFFFF. `DIVU` with 7 ÷ 0: `result`=0xFFFFFFFF, `result_hi`=7.
- `start`=`ADD` pulsed mid-`MULT`: ignored, no extra `done`. `MULTU` followed by `SLL` presented in the `done` cycle: `SLL` result arrives 1 cycle later.
- `RST` at `RUN` cycle 10 of a `DIVU`: outputs 0 at that edge, no `done` afterwards. Build without `ALU_ITER_DIV_EN`: `DIVU` start gives no `done` and `busy`=0.
